// File: rtl/fp_sub_seq_32bit.sv
// rtl/fp_sub_seq_32bit.sv - multi-cycle IEEE-754 single-precision subtractor, result = a - b
// Define FPS_ROUND_NEAREST_EN for round-to-nearest-even in PACK; the default build truncates.
module fp_sub_seq_32bit #(
  parameter int          NORM_SHIFT = 1,
  parameter logic [31:0] CANON_NAN  = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ADD,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  localparam logic [4:0] NSH = 5'(NORM_SHIFT);

  state_t      state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic [9:0]  exp_q, exp_d;
  logic [26:0] x_q, x_d, y_q, y_d, mant_q, mant_d;
  logic [4:0]  k_q, k_d;
  logic [31:0] result_q, result_d;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n = n + 5'd1;
    end
    return n;
  endfunction

  logic        a_nan, a_inf, b_nan, b_inf;
  assign a_nan = (&a[30:23]) & (|a[22:0]);
  assign a_inf = (&a[30:23]) & ~(|a[22:0]);
  assign b_nan = (&b[30:23]) & (|b[22:0]);
  assign b_inf = (&b[30:23]) & ~(|b[22:0]);

  // Operand alignment; b is negated here so the rest of the datapath is a plain signed add.
  logic [7:0]  ea, eb, ex, ey, d;
  logic [23:0] ma, mb, mx, my;
  logic        sb_eff, a_ge, sx;
  logic [26:0] y_ext, y_sh, y_al;
  logic        y_lost;
  assign ea     = opa_q[30:23];
  assign eb     = opb_q[30:23];
  assign ma     = {|ea, opa_q[22:0]};
  assign mb     = {|eb, opb_q[22:0]};
  assign sb_eff = ~opb_q[31];
  assign a_ge   = opa_q[30:0] >= opb_q[30:0];
  assign ex     = a_ge ? ea : eb;
  assign mx     = a_ge ? ma : mb;
  assign sx     = a_ge ? opa_q[31] : sb_eff;
  assign ey     = a_ge ? eb : ea;
  assign my     = a_ge ? mb : ma;
  assign d      = ex - ey;
  assign y_ext  = {my, 3'b000};
  assign y_sh   = y_ext >> d;
  assign y_lost = |(y_ext & ((27'd1 << d) - 27'd1));
  assign y_al   = (d >= 8'd27) ? {26'd0, |my} : (y_sh | {26'd0, y_lost});

  logic [27:0] sum28;
  logic [4:0]  lz, sh;
  assign sum28 = sub_q ? ({1'b0, x_q} - {1'b0, y_q}) : ({1'b0, x_q} + {1'b0, y_q});
  assign lz    = lzc27(sum28[26:0]);
  assign sh    = (k_q < NSH) ? k_q : NSH;

  logic        rnd_up;
  logic [24:0] m25;
  logic [22:0] frac;
  logic [9:0]  exp_r;
`ifdef FPS_ROUND_NEAREST_EN
  assign rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
  assign rnd_up = 1'b0;
`endif
  assign m25   = {1'b0, mant_q[26:3]} + {24'd0, rnd_up};
  assign frac  = m25[24] ? m25[23:1] : m25[22:0];
  assign exp_r = exp_q + {9'd0, m25[24]};

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    x_d       = x_q;
    y_d       = y_q;
    mant_d    = mant_q;
    k_d       = k_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (a_nan || b_nan || (a_inf && b_inf && (a[31] == b[31]))) begin
            result_d = CANON_NAN;
            state_d  = S_DONE;
          end else if (a_inf) begin
            result_d = a;
            state_d  = S_DONE;
          end else if (b_inf) begin
            result_d = {~b[31], 8'hFF, 23'd0};
            state_d  = S_DONE;
          end else begin
            opa_d   = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
            opb_d   = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
            state_d = S_UNPACK;
          end
        end
      end
      S_UNPACK: begin
        x_d     = {mx, 3'b000};
        y_d     = y_al;
        exp_d   = {2'b00, ex};
        sign_d  = sx;
        sub_d   = opa_q[31] ^ sb_eff;
        zero_d  = 1'b0;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (sum28 == 28'd0) begin
          zero_d  = 1'b1;
          sign_d  = 1'b0;
          mant_d  = 27'd0;
          state_d = S_PACK;
        end else if (sum28[27]) begin
          mant_d  = {sum28[27:2], sum28[1] | sum28[0]};
          exp_d   = exp_q + 10'd1;
          state_d = S_PACK;
        end else begin
          mant_d  = sum28[26:0];
          k_d     = lz;
          state_d = (lz != 5'd0) ? S_NORM : S_PACK;
        end
      end
      S_NORM: begin
        if (exp_q <= {5'd0, sh}) begin
          zero_d  = 1'b1;
          state_d = S_PACK;
        end else begin
          mant_d = mant_q << sh;
          exp_d  = exp_q - {5'd0, sh};
          k_d    = k_q - sh;
          if (k_q == sh) state_d = S_PACK;
        end
      end
      S_PACK: begin
        if (zero_q) result_d = {sign_q, 31'd0};
        else if (exp_r >= 10'd255) result_d = {sign_q, 8'hFF, 23'd0};
        else result_d = {sign_q, exp_r[7:0], frac};
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= 10'd0;
      x_q      <= 27'd0;
      y_q      <= 27'd0;
      mant_q   <= 27'd0;
      k_q      <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mant_q   <= mant_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
